// File: rtl/clock_reset_manager.sv
// Purpose: PLL lock filter, staggered per-channel reset release and per-channel clock-enable dividers.
// Latency: locked_in -> FSM is 2 sync flops + 1 edge; rst_out[i] drops 3+LOCK_FILTER+i*RST_STAGGER edges after lock.
// Backpressure: none; free-running outputs. Optional loss counter built only when CLKMGR_LOSS_COUNT_EN is defined.
module clock_reset_manager #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILTER = 1024,
  parameter int RST_STAGGER = 16
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    locked_in,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    locked_out,
  output logic [7:0]              lock_lost_cnt
);

  localparam int FILT_W   = $clog2(LOCK_FILTER);
  // Stagger counter tops out at the last channel's release offset; +1 keeps width >= 1 for NUM_CH=1.
  localparam int STAG_MAX = (NUM_CH - 1) * RST_STAGGER + 1;
  localparam int STAG_W   = $clog2(STAG_MAX + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [1:0]        sync_q;
  logic              lock_s;
  state_e            state_q, state_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [STAG_W-1:0] stag_q, stag_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              locked_q;

  assign lock_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked_in};
    end
  end

  // Sequencer state, counters and registered reset / locked outputs.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      filt_q   <= '0;
      stag_q   <= '0;
      rst_q    <= '1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      stag_q   <= stag_d;
      rst_q    <= rst_d;
      locked_q <= (state_d == RUN);
    end
  end

  // Next-state logic: lock loss always wins over forward progress.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    stag_d  = stag_q;
    rst_d   = rst_q;
    case (state_q)
      WAIT_LOCK: begin
        rst_d = '1;
        if (lock_s) begin
          state_d = FILTER;
          filt_d  = '0;
        end
      end
      FILTER: begin
        rst_d = '1;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (filt_q == FILT_W'(LOCK_FILTER - 1)) begin
          // Channel 0 is released on the RELEASE entry edge itself.
          state_d  = RELEASE;
          stag_d   = '0;
          rst_d[0] = 1'b0;
        end else begin
          filt_d = filt_q + FILT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = '1;
        end else if (!rst_q[NUM_CH-1]) begin
          state_d = RUN;
        end else begin
          stag_d = stag_q + STAG_W'(1);
          for (int i = 1; i < NUM_CH; i++) begin
            if (int'(stag_d) == i * RST_STAGGER) begin
              rst_d[i] = 1'b0;
            end
          end
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = '1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '1;
      end
    endcase
  end

  assign rst_out    = rst_q;
  assign locked_out = locked_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    logic [DIV_W-1:0] ratio_now;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_cnt;
    logic             ce_q;

    assign ratio_now = div_ratio[g*DIV_W +: DIV_W];
    // Ratios 0 and 1 both mean "enable every cycle".
    assign last_cnt  = (ratio_q == '0) ? '0 : ratio_q - DIV_W'(1);

    // Divider: held while in reset or being forced back into reset; ratio reloads on release and every wrap.
    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        ratio_q <= '0;
        ce_q    <= 1'b0;
      end else if (rst_q[g] || rst_d[g]) begin
        cnt_q   <= '0;
        ratio_q <= ratio_now;
        ce_q    <= 1'b0;
      end else if (cnt_q == last_cnt) begin
        cnt_q   <= '0;
        ratio_q <= ratio_now;
        ce_q    <= 1'b1;
      end else begin
        cnt_q   <= cnt_q + DIV_W'(1);
        ce_q    <= 1'b0;
      end
    end

    assign ce_out[g] = ce_q;
  end

`ifdef CLKMGR_LOSS_COUNT_EN
  logic [7:0] lost_q;
  logic       loss_evt;

  // A loss only counts once the reset release has started; FILTER aborts are not losses.
  assign loss_evt = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

  // Saturating lock-loss counter.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lost_q <= 8'd0;
    end else if (loss_evt && (lost_q != 8'hFF)) begin
      lost_q <= lost_q + 8'd1;
    end
  end

  assign lock_lost_cnt = lost_q;
`else
  assign lock_lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clock_reset_manager.sv
// Scoreboard bench for clock_reset_manager with NUM_CH=3, LOCK_FILTER=8, RST_STAGGER=4.
// Expected outputs come from an edge-level model of the lock/release/divider rules.
module tb_clock_reset_manager;
  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int LF  = 8;
  localparam int SG  = 4;
`ifdef CLKMGR_LOSS_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              locked_in = 1'b0;
  logic [DW-1:0]     ratio [NCH];
  logic [NCH*DW-1:0] div_ratio;
  logic [NCH-1:0]    rst_out, ce_out;
  logic              locked_out;
  logic [7:0]        lock_lost_cnt;

  assign div_ratio = {ratio[2], ratio[1], ratio[0]};

  always #5 clk = ~clk;

  clock_reset_manager #(
    .NUM_CH(NCH), .DIV_W(DW), .LOCK_FILTER(LF), .RST_STAGGER(SG)
  ) dut (
    .clock_in(clk), .reset(reset), .locked_in(locked_in), .div_ratio(div_ratio),
    .rst_out(rst_out), .ce_out(ce_out), .locked_out(locked_out), .lock_lost_cnt(lock_lost_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  // Model state: synchroniser image, edges since FILTER entry (-1 = waiting), divider schedules.
  bit mf1, mf2;
  int seq_t;
  int m_lost;
  int edge_n = 0;
  bit rel [NCH];
  int nxt [NCH];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [DW-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  task automatic model_reset();
    mf1 = 1'b0;
    mf2 = 1'b0;
    seq_t = -1;
    m_lost = 0;
    for (int i = 0; i < NCH; i++) rel[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    logic [NCH-1:0] r_e, c_e;
    logic l_e;
    edge_n++;
    if (reset) begin
      model_reset();
      exp_q.push_back({{NCH{1'b1}}, {NCH{1'b0}}, 1'b0, 8'd0});
      return;
    end
    ls  = mf2;
    mf2 = mf1;
    mf1 = locked_in;
    if (!ls) begin
      if (seq_t >= LF) begin
`ifdef CLKMGR_LOSS_COUNT_EN
        if (m_lost < 255) m_lost++;
`endif
      end
      seq_t = -1;
    end else if (seq_t < 0) begin
      seq_t = 0;
    end else if (seq_t < 1000) begin
      seq_t++;
    end
    for (int i = 0; i < NCH; i++) begin
      r_e[i] = !(seq_t >= LF + i * SG);
      if (r_e[i]) begin
        rel[i] = 1'b0;
        c_e[i] = 1'b0;
      end else if (!rel[i]) begin
        rel[i] = 1'b1;
        nxt[i] = edge_n + eff(ratio[i]);
        c_e[i] = 1'b0;
      end else if (edge_n == nxt[i]) begin
        c_e[i] = 1'b1;
        nxt[i] = edge_n + eff(ratio[i]);
      end else begin
        c_e[i] = 1'b0;
      end
    end
    l_e = (seq_t >= LF + 1 + (NCH - 1) * SG);
    exp_q.push_back({r_e, c_e, l_e, 8'(m_lost)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Raises locked_in right after the current edge (edge 0) and measures release timing.
  task automatic measure_lock(input string tag);
    int rise;
    int fall [NCH];
    rise = -1;
    for (int i = 0; i < NCH; i++) fall[i] = -1;
    locked_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (rise < 0 && locked_out) rise = e;
      for (int i = 0; i < NCH; i++) if (fall[i] < 0 && !rst_out[i]) fall[i] = e;
    end
    chk({tag, "_locked_rise"}, rise, 4 + LF + (NCH - 1) * SG);
    for (int i = 0; i < NCH; i++) chk($sformatf("%s_rst%0d_fall", tag, i), fall[i], 3 + LF + i * SG);
  endtask

  // Monitor: one expected output vector per edge, compared mid-cycle.
  initial begin
    logic [14:0] ev;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: no expected entry at %0t", $time);
      end else begin
        ev = exp_q.pop_front();
        chk("sb_outputs", int'({rst_out, ce_out, locked_out, lock_lost_cnt}), int'(ev));
      end
    end
  end

  initial begin
    int p [3];
    int np;
    int found;
    ratio[0] = 16'd5;
    ratio[1] = 16'd1;
    ratio[2] = 16'd0;
    model_reset();
    #1 reset = 1'b1;
    #1 chk("reset_values", int'({rst_out, ce_out, locked_out, lock_lost_cnt}), 32'h7000);
    repeat (3) step();
    reset = 1'b0;

    // Clean lock with ratios 5/1/0.
    measure_lock("clean");
    chk("clean_lost", int'(lock_lost_cnt), 0);

    // Mid-period ratio change on channel 0: 5 -> 3.
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      step();
      if (ce_out[0]) found = 1;
    end
    chk("ratio_pulse_found", found, 1);
    step();
    step();
    ratio[0] = 16'd3;
    np = 0;
    for (int i = 0; i < 3; i++) p[i] = -1;
    for (int e = 3; e <= 14; e++) begin
      step();
      if (ce_out[0] && np < 3) begin
        p[np] = e;
        np++;
      end
    end
    chk("ratio_p0", p[0], 5);
    chk("ratio_p1", p[1], 8);
    chk("ratio_p2", p[2], 11);

    // Lock loss in RUN: outputs react on the third edge.
    locked_in = 1'b0;
    step();
    step();
    chk("loss_lat2_locked", int'(locked_out), 1);
    step();
    chk("loss_outputs", int'({rst_out, ce_out, locked_out}), 7'b111_000_0);
    chk("loss_count1", int'(lock_lost_cnt), CNT_EN);

    measure_lock("relock");

    // Filter glitch: a 3-cycle drop inside FILTER restarts the sequence without counting.
    locked_in = 1'b0;
    repeat (4) step();
    locked_in = 1'b1;
    repeat (4) step();
    locked_in = 1'b0;
    repeat (3) step();
    measure_lock("glitch");
    chk("glitch_lost", int'(lock_lost_cnt), 2 * CNT_EN);

    // Async reset pulse while in RELEASE, between clock edges.
    locked_in = 1'b0;
    repeat (4) step();
    locked_in = 1'b1;
    repeat (13) step();
    #5 reset = 1'b1;
    #1 chk("async_reset_values", int'({rst_out, ce_out, locked_out, lock_lost_cnt}), 32'h7000);
    model_reset();
    #1 reset = 1'b0;
    measure_lock("post_reset");

    // Randomised lock toggling and ratio changes.
    repeat (30) begin
      int hold;
      locked_in = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 30);
      repeat (hold) begin
        step();
        if ($urandom_range(0, 4) == 0) ratio[$urandom_range(0, NCH - 1)] = 16'($urandom_range(0, 7));
      end
    end

    // 300 losses inside RELEASE saturate the counter.
    repeat (300) begin
      locked_in = 1'b1;
      repeat (14) step();
      locked_in = 1'b0;
      repeat (4) step();
    end
    chk("loss_saturate", int'(lock_lost_cnt), CNT_EN * 255);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
